// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control FSM for an RV32I core: sequences fetch, decode, execute,
// data access and writeback, owns the bus handshakes/timeouts and instret.
module rv32i_mc_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             branch_cond,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [1:0]       wb_sel,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             trap,
  output logic             bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP, C_SYS, C_ILL
  } cls_t;

  // Wait counter runs 0..TIMEOUT-1 within one access.
  localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           state_r, state_nx;
  cls_t             cls_r, dec_cls_s;
  logic             dec_a_s, dec_b_s;
  logic [1:0]       dec_wb_s;
  logic [TO_W-1:0]  to_cnt_r;
  logic             timeout_s;
  logic [CNT_W-1:0] instret_r;
  logic             bus_err_r;
  logic             alu_a_sel_r, alu_b_sel_r;
  logic [1:0]       wb_sel_r;

  // Opcode classification and the datapath selects each class needs.
  always_comb begin
    dec_cls_s = C_ILL;
    dec_a_s   = 1'b0;
    dec_b_s   = 1'b0;
    dec_wb_s  = 2'b00;
    case (opcode)
      7'b0110111: begin dec_cls_s = C_LUI;   dec_b_s = 1'b1; dec_wb_s = 2'b11; end
      7'b0010111: begin dec_cls_s = C_AUIPC; dec_a_s = 1'b1; dec_b_s = 1'b1; end
      7'b1101111: begin dec_cls_s = C_JAL;   dec_a_s = 1'b1; dec_b_s = 1'b1; dec_wb_s = 2'b10; end
      7'b1100111: begin dec_cls_s = C_JALR;  dec_b_s = 1'b1; dec_wb_s = 2'b10; end
      7'b1100011: begin dec_cls_s = C_BR;    dec_a_s = 1'b1; dec_b_s = 1'b1; end
      7'b0000011: begin dec_cls_s = C_LD;    dec_b_s = 1'b1; dec_wb_s = 2'b01; end
      7'b0100011: begin dec_cls_s = C_ST;    dec_b_s = 1'b1; end
      7'b0010011: begin dec_cls_s = C_OPI;   dec_b_s = 1'b1; end
      7'b0110011: begin dec_cls_s = C_OP; end
      // SYSTEM opcode: func3 000 (ECALL/EBREAK) halts, any other func3 is illegal.
      7'b1110011: begin
        if (func3 == 3'b000) dec_cls_s = C_SYS;
        else                 dec_cls_s = C_ILL;
      end
      default:    dec_cls_s = C_ILL;
    endcase
  end

  // Next-state logic, including bus timeout detection.
  always_comb begin
    state_nx  = state_r;
    timeout_s = 1'b0;
    case (state_r)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_nx = S_DECODE;
        end else if (to_cnt_r == TO_LAST) begin
          state_nx  = S_TRAP;
          timeout_s = 1'b1;
        end else begin
          state_nx = S_FETCH;
        end
      end
      S_DECODE: begin
        case (dec_cls_s)
          C_ILL:   state_nx = S_TRAP;
          C_SYS:   state_nx = S_HALT;
          default: state_nx = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_r)
          C_BR:       state_nx = S_FETCH;
          C_LD, C_ST: state_nx = S_MEM;
          default:    state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (cls_r == C_ST) state_nx = S_FETCH;
          else               state_nx = S_WB;
        end else if (to_cnt_r == TO_LAST) begin
          state_nx  = S_TRAP;
          timeout_s = 1'b1;
        end else begin
          state_nx = S_MEM;
        end
      end
      S_WB:    state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_TRAP;
    endcase
  end

  // Handshake and pulse outputs decoded from the current state.
  always_comb begin
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    retire   = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_EXEC: begin
        if (cls_r == C_BR) begin
          pc_we  = 1'b1;
          pc_sel = branch_cond;
          retire = 1'b1;
        end else begin
          pc_we  = 1'b0;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_r == C_ST);
        if ((cls_r == C_ST) && dmem_ack) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end else begin
          retire = 1'b0;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        pc_sel = (cls_r == C_JAL) || (cls_r == C_JALR);
      end
      default: imem_req = 1'b0;
    endcase
    halted = (state_r == S_HALT);
    trap   = (state_r == S_TRAP);
  end

  // State register and per-access wait counter (cleared on every transition).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      to_cnt_r <= '0;
    end else begin
      state_r <= state_nx;
      if (state_nx != state_r)
        to_cnt_r <= '0;
      else if ((state_r == S_FETCH) || (state_r == S_MEM))
        to_cnt_r <= to_cnt_r + TO_W'(1);
      else
        to_cnt_r <= to_cnt_r;
    end
  end

  // Instruction class and selects captured in DECODE, held until next decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_r       <= C_ILL;
      alu_a_sel_r <= 1'b0;
      alu_b_sel_r <= 1'b0;
      wb_sel_r    <= 2'b00;
    end else if (state_r == S_DECODE) begin
      cls_r       <= dec_cls_s;
      alu_a_sel_r <= dec_a_s;
      alu_b_sel_r <= dec_b_s;
      wb_sel_r    <= dec_wb_s;
    end else begin
      cls_r       <= cls_r;
      alu_a_sel_r <= alu_a_sel_r;
      alu_b_sel_r <= alu_b_sel_r;
      wb_sel_r    <= wb_sel_r;
    end
  end

  // Retired-instruction counter and sticky timeout cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
      bus_err_r <= 1'b0;
    end else begin
      if (retire) instret_r <= instret_r + CNT_W'(1);
      else        instret_r <= instret_r;
      if (timeout_s) bus_err_r <= 1'b1;
      else           bus_err_r <= bus_err_r;
    end
  end

  assign instret   = instret_r;
  assign bus_err   = bus_err_r;
  assign alu_a_sel = alu_a_sel_r;
  assign alu_b_sel = alu_b_sel_r;
  assign wb_sel    = wb_sel_r;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Self-checking bench for rv32i_mc_ctrl: directed vector table, reset corner
// cases and randomized instruction streams against a cycle-schedule model.
module tb_rv32i_mc_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_BR  = 7'b1100011, OP_LD    = 7'b0000011,
                         OP_ST  = 7'b0100011, OP_OPI   = 7'b0010011,
                         OP_OP  = 7'b0110011, OP_SYS   = 7'b1110011;

  localparam int K_ILL = 0, K_HALT = 1, K_BR = 2, K_LD = 3, K_ST = 4, K_WB = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             imem_req, imem_ack = 1'b0, ir_load;
  logic [6:0]       opcode = 7'd0;
  logic [2:0]       func3 = 3'd0;
  logic             branch_cond = 1'b0;
  logic             dmem_req, dmem_we, dmem_ack = 1'b0;
  logic             alu_a_sel, alu_b_sel;
  logic [1:0]       wb_sel;
  logic             rf_we, pc_we, pc_sel, retire;
  logic [CNT_W-1:0] instret;
  logic             halted, trap, bus_err;

  rv32i_mc_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
    .ir_load(ir_load), .opcode(opcode), .func3(func3), .branch_cond(branch_cond),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
    .instret(instret), .halted(halted), .trap(trap), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               ncyc = 0;
  int               nret_seen = 0;
  logic [CNT_W-1:0] exp_instret = '0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    int         fd;
    int         md;
    logic       bc;
    int         cyc;
    int         ret;
    logic       term;
  } vec_t;

  vec_t tbl[16];

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_SYS:  return (f3 == 3'd0) ? K_HALT : K_ILL;
      OP_BR:   return K_BR;
      OP_LD:   return K_LD;
      OP_ST:   return K_ST;
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPI, OP_OP: return K_WB;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] wb_of(input logic [6:0] op);
    case (op)
      OP_LUI:          return 2'b11;
      OP_LD:           return 2'b01;
      OP_JAL, OP_JALR: return 2'b10;
      default:         return 2'b00;
    endcase
  endfunction

  // {checked, alu_a_sel, alu_b_sel} for classes whose operand choice is fixed by the ISA
  function automatic logic [2:0] sel_of(input logic [6:0] op);
    case (op)
      OP_OP:                         return 3'b100;
      OP_OPI, OP_LD, OP_ST, OP_JALR: return 3'b101;
      OP_AUIPC:                      return 3'b111;
      default:                       return 3'b000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, then compare outputs.
  // exp = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire}
  task automatic cyc(input logic ia, input logic da, input logic dec,
                     input logic [6:0] op, input logic [2:0] f3, input logic bc,
                     input logic [7:0] exp, input string nm);
    logic [7:0] mask, act;
    @(negedge clk);
    imem_ack    = ia;
    dmem_ack    = da;
    branch_cond = bc;
    opcode      = dec ? op : 7'($urandom);
    func3       = dec ? f3 : 3'($urandom);
    #1;
    mask = 8'hFF;
    if (!exp[2]) mask[1] = 1'b0;
    if (!exp[5]) mask[4] = 1'b0;
    act = {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire};
    check(nm, 32'(act & mask), 32'(exp & mask));
    check({nm, "_instret"}, 32'(instret), 32'(exp_instret));
    ncyc++;
    if (retire) nret_seen++;
    if (exp[0]) exp_instret = exp_instret + CNT_W'(1);
  endtask

  task automatic terminal(input logic e_trap, input logic e_halt, input logic e_bus);
    for (int i = 0; i < 3; i++) begin
      cyc(rb(), rb(), 1'b0, 7'd0, 3'd0, rb(), 8'h00, "terminal");
      check("sticky_status", {29'd0, trap, halted, bus_err}, {29'd0, e_trap, e_halt, e_bus});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_outs_now", {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, retire,
                           trap, halted, bus_err}, 32'd0);
    check("rst_instret_now", 32'(instret), 32'd0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold", {imem_req, ir_load, dmem_req, rf_we, pc_we, retire, trap, halted,
                       alu_a_sel, alu_b_sel, wb_sel}, 32'd0);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    exp_instret = '0;
    cyc(rb(), rb(), 1'b0, 7'd0, 3'd0, rb(), 8'h00, "idle");
  endtask

  // Model: expected schedule derived from fetch wait, class and data wait.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fd,
                           input int md, input logic bc,
                           output int ncy, output int nret, output logic term);
    int k, n, c0, r0;
    logic a, st, e_bus, e_halt;
    logic [2:0] sel;
    k = kind_of(op, f3);
    st = (k == K_ST);
    c0 = ncyc; r0 = nret_seen;
    term = 1'b0; e_bus = 1'b0; e_halt = 1'b0;
    n = (fd >= TIMEOUT) ? TIMEOUT : fd + 1;
    for (int i = 0; i < n; i++) begin
      a = (i == fd);
      cyc(a, rb(), 1'b0, op, f3, rb(), {1'b1, a, 6'b0}, "fetch");
    end
    if (fd >= TIMEOUT) begin
      term = 1'b1; e_bus = 1'b1;
    end else begin
      cyc(1'b0, rb(), 1'b1, op, f3, rb(), 8'h00, "decode");
      if (k == K_ILL || k == K_HALT) begin
        term = 1'b1; e_halt = (k == K_HALT);
      end else begin
        if (k == K_BR) cyc(rb(), rb(), 1'b0, op, f3, bc, {5'b0, 1'b1, bc, 1'b1}, "exec_br");
        else           cyc(rb(), rb(), 1'b0, op, f3, rb(), 8'h00, "exec");
        sel = sel_of(op);
        if (sel[2]) check("alu_sel", {30'd0, alu_a_sel, alu_b_sel}, {30'd0, sel[1:0]});
        if (k == K_LD || k == K_ST) begin
          n = (md >= TIMEOUT) ? TIMEOUT : md + 1;
          for (int i = 0; i < n; i++) begin
            a = (i == md);
            cyc(rb(), a, 1'b0, op, f3, rb(),
                {2'b0, 1'b1, st, 1'b0, st & a, 1'b0, st & a}, "mem");
          end
          if (md >= TIMEOUT) begin
            term = 1'b1; e_bus = 1'b1;
          end
        end
        if (!term && k != K_BR && k != K_ST) begin
          cyc(rb(), rb(), 1'b0, op, f3, rb(),
              {4'b0, 1'b1, 1'b1, (op == OP_JAL) || (op == OP_JALR), 1'b1}, "wb");
          check("wb_sel", 32'(wb_sel), 32'(wb_of(op)));
        end
      end
    end
    ncy  = ncyc - c0;
    nret = nret_seen - r0;
    if (term) terminal(!e_halt, e_halt, e_bus);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int   ncy, nret, k, dly;
    logic term;
    logic [6:0] legal_ops[9];
    logic [6:0] op;
    logic [2:0] f3;

    legal_ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_OPI, OP_OP};

    //              op        f3     fd  md  bc    cyc ret term
    tbl[0]  = '{OP_OP,    3'd0,  0,  0, 1'b0,  4, 1, 1'b0}; // ADD 0x002080b3
    tbl[1]  = '{OP_LD,    3'd2,  0,  3, 1'b0,  8, 1, 1'b0}; // LW, ack 3 late
    tbl[2]  = '{OP_BR,    3'd0,  0,  0, 1'b1,  3, 1, 1'b0}; // BEQ taken
    tbl[3]  = '{OP_BR,    3'd0,  2,  0, 1'b0,  5, 1, 1'b0}; // BEQ not taken
    tbl[4]  = '{OP_ST,    3'd2,  1,  0, 1'b0,  5, 1, 1'b0};
    tbl[5]  = '{OP_LUI,   3'd0,  0,  0, 1'b0,  4, 1, 1'b0};
    tbl[6]  = '{OP_JAL,   3'd0,  0,  0, 1'b0,  4, 1, 1'b0};
    tbl[7]  = '{OP_JALR,  3'd0,  1,  0, 1'b0,  5, 1, 1'b0};
    tbl[8]  = '{OP_AUIPC, 3'd0,  3,  0, 1'b0,  7, 1, 1'b0};
    tbl[9]  = '{OP_OPI,   3'd0, 15,  0, 1'b0, 19, 1, 1'b0}; // ack in 16th fetch cycle
    tbl[10] = '{OP_ST,    3'd0,  0, 15, 1'b0, 19, 1, 1'b0}; // ack in 16th mem cycle
    tbl[11] = '{7'd0,     3'd0,  0,  0, 1'b0,  2, 0, 1'b1}; // illegal opcode
    tbl[12] = '{OP_SYS,   3'd0,  0,  0, 1'b0,  2, 0, 1'b1}; // ECALL
    tbl[13] = '{OP_OP,    3'd0, 16,  0, 1'b0, 16, 0, 1'b1}; // fetch timeout
    tbl[14] = '{OP_LD,    3'd2,  0, 16, 1'b0, 19, 0, 1'b1}; // load timeout
    tbl[15] = '{OP_LD,    3'd0,  0, 15, 1'b0, 20, 1, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].fd, tbl[i].md, tbl[i].bc, ncy, nret, term);
      check($sformatf("vec%0d_cycles", i), 32'(ncy), 32'(tbl[i].cyc));
      check($sformatf("vec%0d_retires", i), 32'(nret), 32'(tbl[i].ret));
      check($sformatf("vec%0d_term", i), 32'(term), 32'(tbl[i].term));
      if (term) do_reset();
    end

    // Reset asserted while a load is waiting in MEM, after one retirement.
    run_instr(OP_OP, 3'd0, 0, 0, 1'b0, ncy, nret, term);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, {1'b1, 1'b1, 6'b0}, "mm_fetch");
    cyc(1'b0, 1'b0, 1'b1, OP_LD, 3'd2, 1'b0, 8'h00, "mm_decode");
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, 8'h00, "mm_exec");
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 3'd0, 1'b0, {2'b0, 1'b1, 5'b0}, "mm_mem");
    do_reset();
    run_instr(OP_OP, 3'd0, 0, 0, 1'b0, ncy, nret, term);
    check("post_rst_cycles", 32'(ncy), 32'd4);

    // Randomized stream; instret is 4 bits wide so it wraps repeatedly.
    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(0, 40);
      if (k < 36)      begin op = legal_ops[k % 9]; f3 = 3'($urandom); end
      else if (k < 38) begin op = OP_SYS; f3 = 3'd0; end
      else             begin op = (k == 38) ? 7'b1111111 : 7'b0001011; f3 = 3'($urandom); end
      dly = ($urandom_range(0, 14) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 2);
      run_instr(op, f3, dly,
                ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 3),
                rb(), ncy, nret, term);
      if (term) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
